mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, ack-wait cycles before a transaction is aborted (8-bit counter, 1..255).
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 if_mc_en  in  1  fetch read request; requester holds it until mc_if_valid.
REQ-005 if_mc_addr  in  32  fetch word address.
REQ-006 mc_if_data  out  32  fetch read data; registered; valid when mc_if_valid is high.
REQ-007 mc_if_valid  out  1  one-cycle completion pulse for fetch.
REQ-008 arb_if_stall  out  1  combinational: if_mc_en & ~mc_if_valid.
REQ-009 mem_mc_en  in  1  data request; held until mc_mem_done.
REQ-010 mem_mc_rw  in  1  1 = write, 0 = read.
REQ-011 mem_mc_addr  in  32  data address.
REQ-012 mem_mc_wdata  in  32  write data.
REQ-013 mc_mem_data  out  32  data read result; registered.
REQ-014 mc_mem_done  out  1  one-cycle completion pulse for data (read or write).
REQ-015 arb_mem_stall  out  1  combinational: mem_mc_en & ~mc_mem_done.
REQ-016 arb_ram_req  out  1  memory request, held high until ack or timeout.
REQ-017 arb_ram_we  out  1  memory write enable, valid with arb_ram_req.
REQ-018 arb_ram_addr  out  32  memory address.
REQ-019 arb_ram_wdata  out  32  memory write data.
REQ-020 ram_arb_ack  in  1  memory completion, sampled only while arb_ram_req is high.
REQ-021 ram_arb_rdata  in  32  memory read data, valid with ram_arb_ack.
REQ-022 arb_timeout  out  1  sticky flag: a transaction was aborted by timeout.

Function
REQ-023 FSM states: IDLE, FETCH, DATA; arb_ram_req SHALL be high exactly when the state is FETCH or DATA.
REQ-024 Grant rules: only one request pending -> grant it; both pending -> grant the requester not granted last (last_grant register).
REQ-025 Grant from IDLE SHALL occur on the first edge where any request is sampled; arb_ram_req rises the following cycle.
REQ-026 At grant, latch address, we (0 for fetch, mem_mc_rw for data) and wdata; the latched values hold until completion regardless of input changes.
REQ-027 Completion (ack sampled high in FETCH/DATA): fetch -> mc_if_data <= rdata and mc_if_valid pulses next cycle; data read -> mc_mem_data <= rdata and mc_mem_done pulses; data write -> mc_mem_done pulses and mc_mem_data is unchanged.
REQ-028 On the completion edge, re-arbitrate using the pending requests, excluding the requester just completed; if another request is pending, grant it directly (arb_ram_req stays high, no IDLE cycle); otherwise go to IDLE.
REQ-029 A requester whose completion pulse is high SHALL NOT be re-granted in the same cycle; a new request from it is sampled from the next cycle.
REQ-030 Wait counter: cleared at grant; increments each FETCH/DATA cycle without ack.
REQ-031 Timeout: when the counter reaches TIMEOUT with no ack, drop arb_ram_req and set arb_timeout.
REQ-032 On timeout, pulse the owner's completion with data 32'h0; then re-arbitrate as in REQ-028.
REQ-033 Ack and timeout in the same cycle: ack wins and arb_timeout is unchanged.
REQ-034 ram_arb_ack while in IDLE SHALL be ignored.
REQ-035 If a requester drops its en mid-transaction, the transaction still completes and its pulse is still generated.
REQ-036 last_grant updates at every grant.

Reset
REQ-037 On reset low, asynchronously: state IDLE; arb_ram_req, arb_ram_we, mc_if_valid, mc_mem_done and arb_timeout = 0.
REQ-038 Also on reset: arb_ram_addr, arb_ram_wdata, mc_if_data, mc_mem_data and the wait counter = 0.
REQ-039 Reset sets last_grant = FETCH, so data wins the first tie.
REQ-040 Reset asserted mid-transaction SHALL drop arb_ram_req immediately and discard the transaction; no completion pulse is generated.

Verification
REQ-041 Single fetch: fetch addr 0x00000040, ack after 3 cycles with rdata 0x8C220004 -> mc_if_valid pulses 1 cycle and mc_if_data = 0x8C220004; arb_if_stall is high until the pulse.
REQ-042 Tie after reset: fetch and data write (addr 0x100, wdata 0xDEADBEEF) requested together -> data granted first with we=1; fetch granted back-to-back, with no IDLE cycle between the two grants.
REQ-043 Continuous contention: both requesters re-request immediately after each completion, for 6 transactions -> grants alternate D,F,D,F,D,F.
REQ-044 Timeout: data read with ack never given -> arb_ram_req drops after 255 wait cycles; mc_mem_done pulses with mc_mem_data = 0; arb_timeout stays 1 until reset.
REQ-045 Input change: fetch address changes from 0x40 to 0x80 while the fetch is pending -> arb_ram_addr stays 0x40 until ack.
REQ-046 Reset mid-transaction: reset pulsed low mid-transaction -> arb_ram_req = 0 immediately and no completion pulse.
REQ-047 Stray ack: ack asserted while in IDLE -> no output change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between a fetch and a data requester: alternates on
// contention, chains grants without an idle cycle, aborts on ack timeout.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_mc_en,
    input  logic [31:0] if_mc_addr,
    output logic [31:0] mc_if_data,
    output logic        mc_if_valid,
    output logic        arb_if_stall,
    input  logic        mem_mc_en,
    input  logic        mem_mc_rw,
    input  logic [31:0] mem_mc_addr,
    input  logic [31:0] mem_mc_wdata,
    output logic [31:0] mc_mem_data,
    output logic        mc_mem_done,
    output logic        arb_mem_stall,
    output logic        arb_ram_req,
    output logic        arb_ram_we,
    output logic [31:0] arb_ram_addr,
    output logic [31:0] arb_ram_wdata,
    input  logic        ram_arb_ack,
    input  logic [31:0] ram_arb_rdata,
    output logic        arb_timeout
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic            r_last_data;
    logic            r_ram_req;
    logic            r_ram_we;
    logic [DW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_wdata;
    logic [DW-1:0]   r_if_data;
    logic            r_if_valid;
    logic [DW-1:0]   r_mem_data;
    logic            r_mem_done;
    logic            r_timeout;

    logic w_pend_f;
    logic w_pend_d;
    logic w_ack;
    logic w_tmo;
    logic w_done;
    logic w_cand_f;
    logic w_cand_d;
    logic w_grant_f;
    logic w_grant_d;
    logic w_grant;

    // A requester whose completion pulse is high is not yet pending again.
    assign w_pend_f = if_mc_en & ~r_if_valid;
    assign w_pend_d = mem_mc_en & ~r_mem_done;

    assign arb_if_stall  = w_pend_f;
    assign arb_mem_stall = w_pend_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ack        = 1'b0;
        w_tmo        = 1'b0;
        w_cand_f     = 1'b0;
        w_cand_d     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cand_f = w_pend_f;
                w_cand_d = w_pend_d;
            end
            FETCH: begin
                w_ack    = ram_arb_ack;
                w_tmo    = ~ram_arb_ack & (r_cnt == CNT_LAST);
                w_cand_d = w_pend_d & (w_ack | w_tmo);
            end
            DATA: begin
                w_ack    = ram_arb_ack;
                w_tmo    = ~ram_arb_ack & (r_cnt == CNT_LAST);
                w_cand_f = w_pend_f & (w_ack | w_tmo);
            end
            default: w_next_state = IDLE;
        endcase
        w_done    = w_ack | w_tmo;
        // On a tie the requester not granted last wins.
        w_grant_d = w_cand_d & (~w_cand_f | ~r_last_data);
        w_grant_f = w_cand_f & ~w_grant_d;
        w_grant   = w_grant_f | w_grant_d;
        if (w_grant_d) begin
            w_next_state = DATA;
        end else if (w_grant_f) begin
            w_next_state = FETCH;
        end else if (w_done) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_last_data <= 1'b0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_data   <= '0;
            r_if_valid  <= 1'b0;
            r_mem_data  <= '0;
            r_mem_done  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_ram_req  <= (w_next_state != IDLE);
            r_if_valid <= (r_state == FETCH) & w_done;
            r_mem_done <= (r_state == DATA) & w_done;
            if ((r_state == FETCH) && w_done) begin
                r_if_data <= w_ack ? ram_arb_rdata : '0;
            end
            // A completed write leaves the read-data register untouched.
            if ((r_state == DATA) && w_done && (w_tmo || !r_ram_we)) begin
                r_mem_data <= w_ack ? ram_arb_rdata : '0;
            end
            if (w_tmo) begin
                r_timeout <= 1'b1;
            end
            if (w_grant) begin
                r_cnt       <= '0;
                r_last_data <= w_grant_d;
                r_ram_addr  <= w_grant_d ? mem_mc_addr : if_mc_addr;
                r_ram_we    <= w_grant_d & mem_mc_rw;
                r_ram_wdata <= w_grant_d ? mem_mc_wdata : '0;
            end else if (w_done) begin
                r_ram_we <= 1'b0;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign arb_ram_req   = r_ram_req;
    assign arb_ram_we    = r_ram_we;
    assign arb_ram_addr  = r_ram_addr;
    assign arb_ram_wdata = r_ram_wdata;
    assign mc_if_data    = r_if_data;
    assign mc_if_valid   = r_if_valid;
    assign mc_mem_data   = r_mem_data;
    assign mc_mem_done   = r_mem_done;
    assign arb_timeout   = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// scored against a word-level memory model.
module tb_mem_port_arbiter;
    localparam int unsigned TMO = 255;

    logic        clock;
    logic        reset;
    logic        if_mc_en;
    logic [31:0] if_mc_addr;
    logic [31:0] mc_if_data;
    logic        mc_if_valid;
    logic        arb_if_stall;
    logic        mem_mc_en;
    logic        mem_mc_rw;
    logic [31:0] mem_mc_addr;
    logic [31:0] mem_mc_wdata;
    logic [31:0] mc_mem_data;
    logic        mc_mem_done;
    logic        arb_mem_stall;
    logic        arb_ram_req;
    logic        arb_ram_we;
    logic [31:0] arb_ram_addr;
    logic [31:0] arb_ram_wdata;
    logic        ram_arb_ack;
    logic [31:0] ram_arb_rdata;
    logic        arb_timeout;

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_if_data;
    logic [31:0] exp_mem_data;
    logic [31:0] ram     [8];
    logic [31:0] ref_mem [8];

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .clock         (clock),
        .reset         (reset),
        .if_mc_en      (if_mc_en),
        .if_mc_addr    (if_mc_addr),
        .mc_if_data    (mc_if_data),
        .mc_if_valid   (mc_if_valid),
        .arb_if_stall  (arb_if_stall),
        .mem_mc_en     (mem_mc_en),
        .mem_mc_rw     (mem_mc_rw),
        .mem_mc_addr   (mem_mc_addr),
        .mem_mc_wdata  (mem_mc_wdata),
        .mc_mem_data   (mc_mem_data),
        .mc_mem_done   (mc_mem_done),
        .arb_mem_stall (arb_mem_stall),
        .arb_ram_req   (arb_ram_req),
        .arb_ram_we    (arb_ram_we),
        .arb_ram_addr  (arb_ram_addr),
        .arb_ram_wdata (arb_ram_wdata),
        .ram_arb_ack   (ram_arb_ack),
        .ram_arb_rdata (ram_arb_rdata),
        .arb_timeout   (arb_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of run, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset         = 1'b0;
        if_mc_en      = 1'b0;
        if_mc_addr    = 32'h0;
        mem_mc_en     = 1'b0;
        mem_mc_rw     = 1'b0;
        mem_mc_addr   = 32'h0;
        mem_mc_wdata  = 32'h0;
        ram_arb_ack   = 1'b0;
        ram_arb_rdata = 32'h0;
        repeat (2) @(negedge clock);
        reset        = 1'b1;
        exp_if_data  = 32'h0;
        exp_mem_data = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({arb_ram_req, arb_ram_we, mc_if_valid, mc_mem_done, arb_timeout} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {arb_ram_req, arb_ram_we, mc_if_valid, mc_mem_done, arb_timeout});
        else n_pass++;
        n_checks++;
        if ({arb_ram_addr, arb_ram_wdata, mc_if_data, mc_mem_data} !== 128'h0)
            $display("FAIL reset_data: got %h %h %h %h want all zero",
                     arb_ram_addr, arb_ram_wdata, mc_if_data, mc_mem_data);
        else n_pass++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_fetch();
        if_mc_en   = 1'b1;
        if_mc_addr = 32'h40;
        #1;
        n_checks++;
        if (arb_if_stall !== 1'b1) $display("FAIL fetch_stall0: got %b want 1", arb_if_stall);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (arb_ram_req !== 1'b1 || arb_ram_we !== 1'b0 || arb_ram_addr !== 32'h40)
            $display("FAIL fetch_bus: got req %b we %b addr %h want 1 0 00000040",
                     arb_ram_req, arb_ram_we, arb_ram_addr);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            n_checks++;
            if (arb_if_stall !== 1'b1 || mc_if_valid !== 1'b0)
                $display("FAIL fetch_wait%0d: got stall %b valid %b want 1 0", i, arb_if_stall, mc_if_valid);
            else n_pass++;
        end
        ram_arb_ack   = 1'b1;
        ram_arb_rdata = 32'h8C220004;
        @(negedge clock);
        ram_arb_ack   = 1'b0;
        ram_arb_rdata = 32'h0;
        n_checks++;
        if (mc_if_valid !== 1'b1 || mc_if_data !== 32'h8C220004 || arb_if_stall !== 1'b0 || arb_ram_req !== 1'b0)
            $display("FAIL fetch_done: got valid %b data %h stall %b req %b want 1 8c220004 0 0",
                     mc_if_valid, mc_if_data, arb_if_stall, arb_ram_req);
        else n_pass++;
        exp_if_data = 32'h8C220004;
        if_mc_en    = 1'b0;
        @(negedge clock);
        n_checks++;
        if (mc_if_valid !== 1'b0) $display("FAIL fetch_pulse_len: got valid %b want 0", mc_if_valid);
        else n_pass++;
    endtask

    task automatic test_stray_ack();
        ram_arb_ack   = 1'b1;
        ram_arb_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if ({arb_ram_req, mc_if_valid, mc_mem_done, arb_timeout} !== 4'b0 ||
                mc_if_data !== exp_if_data || mc_mem_data !== exp_mem_data)
                $display("FAIL stray_ack%0d: got ctl %b if %h mem %h want 0000 %h %h", i,
                         {arb_ram_req, mc_if_valid, mc_mem_done, arb_timeout},
                         mc_if_data, mc_mem_data, exp_if_data, exp_mem_data);
            else n_pass++;
        end
        ram_arb_ack   = 1'b0;
        ram_arb_rdata = 32'h0;
    endtask

    task automatic test_input_change();
        if_mc_en   = 1'b1;
        if_mc_addr = 32'h40;
        @(negedge clock);
        if_mc_addr = 32'h80;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            n_checks++;
            if (arb_ram_req !== 1'b1 || arb_ram_addr !== 32'h40)
                $display("FAIL addr_hold%0d: got req %b addr %h want 1 00000040", i, arb_ram_req, arb_ram_addr);
            else n_pass++;
        end
        ram_arb_ack   = 1'b1;
        ram_arb_rdata = 32'h12345678;
        @(negedge clock);
        ram_arb_ack = 1'b0;
        n_checks++;
        if (mc_if_valid !== 1'b1 || mc_if_data !== 32'h12345678)
            $display("FAIL addr_hold_done: got valid %b data %h want 1 12345678", mc_if_valid, mc_if_data);
        else n_pass++;
        if_mc_en = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_tie();
        do_reset();
        if_mc_en     = 1'b1;
        if_mc_addr   = 32'h200;
        mem_mc_en    = 1'b1;
        mem_mc_rw    = 1'b1;
        mem_mc_addr  = 32'h100;
        mem_mc_wdata = 32'hDEADBEEF;
        @(negedge clock);
        n_checks++;
        if (arb_ram_req !== 1'b1 || arb_ram_we !== 1'b1 || arb_ram_addr !== 32'h100 || arb_ram_wdata !== 32'hDEADBEEF)
            $display("FAIL tie_first: got req %b we %b addr %h wdata %h want 1 1 00000100 deadbeef",
                     arb_ram_req, arb_ram_we, arb_ram_addr, arb_ram_wdata);
        else n_pass++;
        ram_arb_ack   = 1'b1;
        ram_arb_rdata = 32'h5555AAAA;
        @(negedge clock);
        n_checks++;
        if (mc_mem_done !== 1'b1 || mc_mem_data !== 32'h0 || arb_ram_req !== 1'b1 ||
            arb_ram_we !== 1'b0 || arb_ram_addr !== 32'h200)
            $display("FAIL tie_second: got done %b mdata %h req %b we %b addr %h want 1 00000000 1 0 00000200",
                     mc_mem_done, mc_mem_data, arb_ram_req, arb_ram_we, arb_ram_addr);
        else n_pass++;
        mem_mc_en     = 1'b0;
        ram_arb_rdata = 32'h0BADF00D;
        @(negedge clock);
        ram_arb_ack = 1'b0;
        n_checks++;
        if (mc_if_valid !== 1'b1 || mc_if_data !== 32'h0BADF00D || arb_ram_req !== 1'b0)
            $display("FAIL tie_fetch_done: got valid %b data %h req %b want 1 0badf00d 0",
                     mc_if_valid, mc_if_data, arb_ram_req);
        else n_pass++;
        if_mc_en = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_contention();
        int   seen;
        logic owner_d;
        logic exp_d;
        do_reset();
        seen        = 0;
        if_mc_en    = 1'b1;
        if_mc_addr  = 32'h1000;
        mem_mc_en   = 1'b1;
        mem_mc_rw   = 1'b0;
        mem_mc_addr = 32'h2000;
        for (int cyc = 0; cyc < 100 && seen < 6; cyc++) begin
            @(negedge clock);
            ram_arb_ack = 1'b0;
            if (mc_if_valid === 1'b1) begin
                n_checks++;
                if (mc_if_data !== {16'hC0DE, if_mc_addr[15:0]})
                    $display("FAIL cont_fetch_data: got %h want %h", mc_if_data, {16'hC0DE, if_mc_addr[15:0]});
                else n_pass++;
                if_mc_addr = if_mc_addr + 32'h1;
            end
            if (mc_mem_done === 1'b1) begin
                n_checks++;
                if (mc_mem_data !== {16'hC0DE, mem_mc_addr[15:0]})
                    $display("FAIL cont_data_data: got %h want %h", mc_mem_data, {16'hC0DE, mem_mc_addr[15:0]});
                else n_pass++;
                mem_mc_addr = mem_mc_addr + 32'h1;
            end
            if (arb_ram_req === 1'b1) begin
                owner_d = (arb_ram_addr[13:12] == 2'd2);
                exp_d   = (seen % 2 == 0);
                n_checks++;
                if (owner_d !== exp_d)
                    $display("FAIL cont_grant%0d: got %s want %s", seen, owner_d ? "D" : "F", exp_d ? "D" : "F");
                else n_pass++;
                seen++;
                ram_arb_ack   = 1'b1;
                ram_arb_rdata = {16'hC0DE, arb_ram_addr[15:0]};
            end
        end
        n_checks++;
        if (seen != 6) $display("FAIL cont_count: got %0d grants want 6", seen);
        else n_pass++;
        if_mc_en  = 1'b0;
        mem_mc_en = 1'b0;
        repeat (4) begin
            @(negedge clock);
            ram_arb_ack = arb_ram_req;
        end
        ram_arb_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        mem_mc_en   = 1'b1;
        mem_mc_rw   = 1'b0;
        mem_mc_addr = 32'h300;
        @(negedge clock);
        ram_arb_ack   = 1'b1;
        ram_arb_rdata = 32'hCAFEF00D;
        @(negedge clock);
        ram_arb_ack = 1'b0;
        mem_mc_en   = 1'b0;
        n_checks++;
        if (mc_mem_done !== 1'b1 || mc_mem_data !== 32'hCAFEF00D || arb_timeout !== 1'b0)
            $display("FAIL tmo_pre_read: got done %b data %h tmo %b want 1 cafef00d 0",
                     mc_mem_done, mc_mem_data, arb_timeout);
        else n_pass++;
        @(negedge clock);
        mem_mc_en   = 1'b1;
        mem_mc_addr = 32'h304;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (arb_ram_req === 1'b1) cnt++;
            else if (cnt > 0) break;
        end
        n_checks++;
        if (cnt != int'(TMO)) $display("FAIL tmo_cycles: got %0d want %0d", cnt, TMO);
        else n_pass++;
        n_checks++;
        if (mc_mem_done !== 1'b1 || mc_mem_data !== 32'h0 || arb_timeout !== 1'b1)
            $display("FAIL tmo_abort: got done %b data %h tmo %b want 1 00000000 1",
                     mc_mem_done, mc_mem_data, arb_timeout);
        else n_pass++;
        mem_mc_en  = 1'b0;
        if_mc_en   = 1'b1;
        if_mc_addr = 32'h44;
        @(negedge clock);
        ram_arb_ack   = 1'b1;
        ram_arb_rdata = 32'h1;
        @(negedge clock);
        ram_arb_ack = 1'b0;
        if_mc_en    = 1'b0;
        @(negedge clock);
        n_checks++;
        if (arb_timeout !== 1'b1 || mc_mem_done !== 1'b0)
            $display("FAIL tmo_sticky: got tmo %b done %b want 1 0", arb_timeout, mc_mem_done);
        else n_pass++;
        do_reset();
        #1;
        n_checks++;
        if (arb_timeout !== 1'b0) $display("FAIL tmo_clear: got %b want 0", arb_timeout);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        f_out;
        logic        d_out;
        logic        d_rw;
        logic        rsp_busy;
        logic [2:0]  f_idx;
        logic [2:0]  d_idx;
        logic [2:0]  idx;
        logic [31:0] d_wdata;
        int          f_age;
        int          d_age;
        int          max_age;
        int          rsp_wait;
        int          n_done;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        f_out = 1'b0; d_out = 1'b0; d_rw = 1'b0; rsp_busy = 1'b0;
        f_idx = 3'd0; d_idx = 3'd0; d_wdata = 32'h0;
        f_age = 0; d_age = 0; max_age = 0; rsp_wait = 0; n_done = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clock);
            ram_arb_ack = 1'b0;
            if (mc_if_valid === 1'b1) begin
                n_checks++;
                if (!f_out || mc_if_data !== ref_mem[f_idx])
                    $display("FAIL rand_fetch c%0d: got %h want %h (outstanding %b)", cyc, mc_if_data, ref_mem[f_idx], f_out);
                else n_pass++;
                f_out = 1'b0;
                n_done++;
            end
            if (mc_mem_done === 1'b1) begin
                if (d_out && d_rw) ref_mem[d_idx] = d_wdata;
                else if (d_out) exp_mem_data = ref_mem[d_idx];
                n_checks++;
                if (!d_out || mc_mem_data !== exp_mem_data)
                    $display("FAIL rand_data c%0d: got %h want %h (outstanding %b rw %b)", cyc, mc_mem_data, exp_mem_data, d_out, d_rw);
                else n_pass++;
                d_out = 1'b0;
                n_done++;
            end
            if (arb_ram_req === 1'b1) begin
                if (!rsp_busy) begin
                    rsp_busy = 1'b1;
                    rsp_wait = int'($urandom_range(0, 3));
                end
                if (rsp_wait == 0) begin
                    idx           = arb_ram_addr[2:0];
                    ram_arb_ack   = 1'b1;
                    ram_arb_rdata = ram[idx];
                    if (arb_ram_we) ram[idx] = arb_ram_wdata;
                    rsp_busy = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end else begin
                rsp_busy = 1'b0;
                if ($urandom_range(0, 7) == 0) begin
                    ram_arb_ack   = 1'b1;
                    ram_arb_rdata = $urandom;
                end
            end
            if (!f_out && $urandom_range(0, 2) == 0) begin
                f_out = 1'b1;
                f_idx = 3'($urandom_range(0, 7));
                f_age = 0;
            end
            if (!d_out && $urandom_range(0, 2) == 0) begin
                d_out   = 1'b1;
                d_rw    = 1'($urandom_range(0, 1));
                d_idx   = 3'($urandom_range(0, 7));
                d_wdata = $urandom;
                d_age   = 0;
            end
            if (f_out) f_age++;
            if (d_out) d_age++;
            if (f_age > max_age) max_age = f_age;
            if (d_age > max_age) max_age = d_age;
            if_mc_en     = f_out;
            if_mc_addr   = {29'h0, f_idx};
            mem_mc_en    = d_out;
            mem_mc_rw    = d_rw;
            mem_mc_addr  = {29'h0, d_idx};
            mem_mc_wdata = d_wdata;
            #1;
            n_checks++;
            if (arb_if_stall !== (f_out & ~mc_if_valid) || arb_mem_stall !== (d_out & ~mc_mem_done))
                $display("FAIL rand_stall c%0d: got %b%b want %b%b", cyc, arb_if_stall, arb_mem_stall,
                         f_out & ~mc_if_valid, d_out & ~mc_mem_done);
            else n_pass++;
        end
        n_checks++;
        if (max_age > 30 || n_done < 100 || arb_timeout !== 1'b0)
            $display("FAIL rand_progress: got max_wait %0d completions %0d tmo %b want <=30 >=100 0",
                     max_age, n_done, arb_timeout);
        else n_pass++;
        ram_arb_ack = 1'b0;
        if_mc_en    = 1'b0;
        mem_mc_en   = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic quiet;
        do_reset();
        if_mc_en   = 1'b1;
        if_mc_addr = 32'h40;
        @(negedge clock);
        n_checks++;
        if (arb_ram_req !== 1'b1) $display("FAIL mid_req_up: got %b want 1", arb_ram_req);
        else n_pass++;
        #2;
        reset    = 1'b0;
        if_mc_en = 1'b0;
        #1;
        n_checks++;
        if (arb_ram_req !== 1'b0) $display("FAIL mid_req_drop: got %b want 0", arb_ram_req);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (mc_if_valid !== 1'b0 || mc_mem_done !== 1'b0 || arb_ram_req !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) $display("FAIL mid_no_pulse: got activity %b want none", ~quiet);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_fetch();
        test_stray_ack();
        test_input_change();
        test_tie();
        test_contention();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
